detect_window_counter: RTL and testbench

Downstream consumer of the serial `0110` pattern detector. It counts `detect_out` pulses over fixed windows of `WINDOW_CYCLES` clocks and, at each window end, publishes a count report through a valid/ready handshake. The report is held in a one-entry buffer that flags overrun. It sits between the detector and the control/readout logic, which drains reports at its own pace.

---
 rtl/detect_pkg.sv | 18 +
 rtl/detect_rpt_buffer.sv | 56 +++++
 rtl/detect_window_counter.sv | 104 ++++++++++
 tb/tb_detect_window_counter.sv | 177 +++++++++++++++++
 4 files changed

// File: rtl/detect_pkg.sv
`default_nettype none
// ============================================================================
// Module      : detect_pkg
// Description : Shared types and constants for the detect window counter.
// Revision    : 1.0
// ============================================================================
package detect_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    localparam int c_default_cnt_w = 8;
    localparam int c_win_w         = 16;

endpackage
`default_nettype wire

// File: rtl/detect_rpt_buffer.sv
`default_nettype none
// ============================================================================
// Module      : detect_rpt_buffer
// Description : One-entry report register with valid/ready and overrun flag.
// Revision    : 1.0
// ============================================================================
module detect_rpt_buffer
    import detect_pkg::*;
#(
    parameter int CNT_W = c_default_cnt_w
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load,
    input  logic [CNT_W-1:0] load_count,
    input  logic             load_sat,
    input  logic             rpt_ready,
    output logic             rpt_valid,
    output logic [CNT_W-1:0] rpt_count,
    output logic             rpt_sat,
    output logic             rpt_overrun
);

    logic             r_valid;
    logic [CNT_W-1:0] r_count;
    logic             r_sat;
    logic             r_overrun;
    logic             w_accept;

    assign w_accept = r_valid & rpt_ready;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_valid   <= 1'b0;
            r_count   <= '0;
            r_sat     <= 1'b0;
            r_overrun <= 1'b0;
        end else if (load) begin
            // Overrun only when an unaccepted report is being replaced.
            r_valid   <= 1'b1;
            r_count   <= load_count;
            r_sat     <= load_sat;
            r_overrun <= r_valid & ~rpt_ready;
        end else if (w_accept) begin
            r_valid   <= 1'b0;
            r_overrun <= 1'b0;
        end
    end

    assign rpt_valid   = r_valid;
    assign rpt_count   = r_count;
    assign rpt_sat     = r_sat;
    assign rpt_overrun = r_overrun;

endmodule
`default_nettype wire

// File: rtl/detect_window_counter.sv
`default_nettype none
// ============================================================================
// Module      : detect_window_counter
// Description : Counts detector pulses per fixed window and publishes reports.
// Revision    : 1.0
// ============================================================================
module detect_window_counter
    import detect_pkg::*;
#(
    parameter int WINDOW_CYCLES = 1000,
    parameter int CNT_W         = c_default_cnt_w
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             detect_in,
    input  logic             enable,
    output logic             rpt_valid,
    input  logic             rpt_ready,
    output logic [CNT_W-1:0] rpt_count,
    output logic             rpt_sat,
    output logic             rpt_overrun,
    output logic             busy
);

    localparam logic [c_win_w-1:0] c_win_last = c_win_w'(WINDOW_CYCLES - 1);
    localparam logic [CNT_W-1:0]   c_cnt_max  = '1;

    state_t             r_state;
    state_t             w_state_next;
    logic [c_win_w-1:0] r_win_cnt;
    logic [CNT_W-1:0]   r_live_cnt;
    logic               r_live_sat;

    logic               w_run;
    logic               w_stay;
    logic               w_hit;
    logic               w_win_end;
    logic               w_live_at_max;
    logic [CNT_W-1:0]   w_live_cnt_next;
    logic               w_live_sat_next;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            IDLE:    if (enable)  w_state_next = RUN;
            RUN:     if (!enable) w_state_next = IDLE;
            default: w_state_next = IDLE;
        endcase
    end

    assign w_run         = (r_state == RUN);
    assign w_stay        = w_run & enable;
    assign w_hit         = w_run & detect_in;
    assign w_win_end     = w_run && (r_win_cnt == c_win_last);
    assign w_live_at_max = (r_live_cnt == c_cnt_max);

    // Count including the current cycle's hit; this is also the report value.
    assign w_live_cnt_next = (w_hit && !w_live_at_max) ? r_live_cnt + CNT_W'(1) : r_live_cnt;
    assign w_live_sat_next = r_live_sat | (w_hit & w_live_at_max);

    // Clearing whenever the next state is IDLE discards any partial window.
    always_ff @(posedge clk) begin
        if (!rst_n || !w_stay) begin
            r_win_cnt  <= '0;
            r_live_cnt <= '0;
            r_live_sat <= 1'b0;
        end else if (w_win_end) begin
            r_win_cnt  <= '0;
            r_live_cnt <= '0;
            r_live_sat <= 1'b0;
        end else begin
            r_win_cnt  <= r_win_cnt + c_win_w'(1);
            r_live_cnt <= w_live_cnt_next;
            r_live_sat <= w_live_sat_next;
        end
    end

    detect_rpt_buffer #(
        .CNT_W (CNT_W)
    ) u_rpt_buffer (
        .clk         (clk),
        .rst_n       (rst_n),
        .load        (w_win_end),
        .load_count  (w_live_cnt_next),
        .load_sat    (w_live_sat_next),
        .rpt_ready   (rpt_ready),
        .rpt_valid   (rpt_valid),
        .rpt_count   (rpt_count),
        .rpt_sat     (rpt_sat),
        .rpt_overrun (rpt_overrun)
    );

    assign busy = w_run;

endmodule
`default_nettype wire

// File: tb/tb_detect_window_counter.sv
`default_nettype none
// ============================================================================
// Module      : tb_detect_window_counter
// Description : Directed self-checking bench, WINDOW_CYCLES=8, CNT_W=3.
// Revision    : 1.0
// ============================================================================
module tb_detect_window_counter;

    localparam int c_win = 8;
    localparam int c_cw  = 3;

    logic            clk;
    logic            rst_n;
    logic            detect_in;
    logic            enable;
    logic            rpt_valid;
    logic            rpt_ready;
    logic [c_cw-1:0] rpt_count;
    logic            rpt_sat;
    logic            rpt_overrun;
    logic            busy;

    int n_checks = 0;
    int n_pass   = 0;

    detect_window_counter #(
        .WINDOW_CYCLES (c_win),
        .CNT_W         (c_cw)
    ) u_dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .detect_in   (detect_in),
        .enable      (enable),
        .rpt_valid   (rpt_valid),
        .rpt_ready   (rpt_ready),
        .rpt_count   (rpt_count),
        .rpt_sat     (rpt_sat),
        .rpt_overrun (rpt_overrun),
        .busy        (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Inputs set after a step are sampled at the next rising edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic run_window(input logic [7:0] hits, input bit quiet, input bit ready_last);
        for (int j = 0; j < c_win; j++) begin
            detect_in = hits[j];
            if (j == c_win - 1 && ready_last) rpt_ready = 1'b1;
            step();
            if (quiet && (j == 0 || j == c_win - 2)) chk("valid_mid_window", rpt_valid, 1'b0);
        end
        detect_in = 1'b0;
    endtask

    task automatic restart();
        enable = 1'b0;
        step();
        step();
        enable = 1'b1;
        step();
    endtask

    task automatic chk_all_zero(input string tag);
        chk(tag, {rpt_valid, busy, rpt_count, rpt_sat, rpt_overrun}, '0);
    endtask

    initial begin
        rst_n     = 1'b0;
        detect_in = 1'b0;
        enable    = 1'b0;
        rpt_ready = 1'b0;
        step();
        step();
        chk_all_zero("reset_state");

        // 1: idle with toggling detect
        rst_n = 1'b1;
        for (int i = 0; i < 20; i++) begin
            detect_in = ~detect_in;
            step();
            if (i % 5 == 4) chk_all_zero("idle_ignores_detect");
        end
        detect_in = 1'b0;

        // 2: hits on window cycles 2, 5, 7
        rpt_ready = 1'b1;
        enable    = 1'b1;
        step();
        chk("busy_after_enable", busy, 1'b1);
        run_window(8'b1010_0100, 1'b1, 1'b0);
        chk("s2_valid", rpt_valid, 1'b1);
        chk("s2_fields", {rpt_count, rpt_sat, rpt_overrun}, {3'd3, 1'b0, 1'b0});

        // 3: saturation, then a fresh window with one hit
        run_window(8'hFF, 1'b1, 1'b0);
        chk("s3_valid_sat", rpt_valid, 1'b1);
        chk("s3_fields_sat", {rpt_count, rpt_sat, rpt_overrun}, {3'd7, 1'b1, 1'b0});
        run_window(8'h08, 1'b1, 1'b0);
        chk("s3_fields_one", {rpt_count, rpt_sat, rpt_overrun}, {3'd1, 1'b0, 1'b0});

        // 4a: consumer stalled across two window ends
        restart();
        rpt_ready = 1'b0;
        run_window(8'h11, 1'b0, 1'b0);
        chk("s4a_first", {rpt_valid, rpt_count, rpt_overrun}, {1'b1, 3'd2, 1'b0});
        step();
        chk("s4a_hold", {rpt_valid, rpt_count}, {1'b1, 3'd2});
        run_window(8'h0F, 1'b0, 1'b0);
        chk("s4a_overrun", {rpt_valid, rpt_count, rpt_overrun}, {1'b1, 3'd4, 1'b1});

        // 4b: accept coincides with the second load
        rpt_ready = 1'b1;
        restart();
        rpt_ready = 1'b0;
        run_window(8'h11, 1'b0, 1'b0);
        chk("s4b_first", {rpt_valid, rpt_count, rpt_overrun}, {1'b1, 3'd2, 1'b0});
        run_window(8'h0F, 1'b0, 1'b1);
        chk("s4b_second", {rpt_valid, rpt_count, rpt_overrun}, {1'b1, 3'd4, 1'b0});
        step();
        chk("s4b_drop", rpt_valid, 1'b0);

        // 5: partial window discarded
        restart();
        for (int j = 0; j < 4; j++) begin
            detect_in = (j < 3);
            step();
        end
        detect_in = 1'b0;
        enable    = 1'b0;
        step();
        chk("s5_idle", {busy, rpt_valid}, 2'b00);
        for (int i = 0; i < 4; i++) step();
        enable = 1'b1;
        step();
        chk("s5_rerun", {busy, rpt_valid}, 2'b10);
        run_window(8'h20, 1'b1, 1'b0);
        chk("s5_report", {rpt_valid, rpt_count, rpt_sat, rpt_overrun}, {1'b1, 3'd1, 1'b0, 1'b0});

        // 6: reset with report pending, mid-window
        rpt_ready = 1'b0;
        for (int j = 0; j < 3; j++) begin
            detect_in = 1'b1;
            step();
        end
        chk("s6_pending", rpt_valid, 1'b1);
        rst_n = 1'b0;
        step();
        rst_n     = 1'b1;
        detect_in = 1'b0;
        chk_all_zero("s6_after_reset");
        step();
        chk("s6_busy", {busy, rpt_valid}, 2'b10);
        rpt_ready = 1'b1;
        run_window(8'h03, 1'b1, 1'b0);
        chk("s6_report", {rpt_valid, rpt_count, rpt_sat, rpt_overrun}, {1'b1, 3'd2, 1'b0, 1'b0});

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
